// File: rtl/mem_bus_responder.sv
// KS10 backplane memory responder: claims memory references from the arbiter's
// address cycles, returns read data after RD_LAT clocks and accepts write data.
module mem_bus_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_addr_cycle_in,
  input  logic        bus_data_cycle_in,
  input  logic        bus_io_cycle_in,
  input  logic [0:35] bus_data_in,
  output logic        bus_data_cycle_out,
  output logic        bus_mem_busy_out,
  output logic [0:35] bus_data_out,
  output logic        mem_nxm,
  output logic        mem_wr_abort
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdData, StWrWait} state_e;

  localparam logic [15:0] RdLast = (RD_LAT > 1) ? 16'(RD_LAT - 2) : 16'd0;
  localparam logic [15:0] WrLast = 16'(WR_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rmw_q, rmw_d;
  logic                    nxm_q, nxm_d;
  logic                    mem_we, abort;

  logic [0:35]             mem [2**ADDR_WIDTH];
  logic [0:35]             rdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr;

  logic                    req_rd, req_wr;
  logic [21:0]             req_addr;
  logic                    out_of_range;
  logic                    unused_bits;

  assign req_rd       = bus_data_in[3];
  assign req_wr       = bus_data_in[5];
  assign req_addr     = bus_data_in[14:35];
  assign out_of_range = |(req_addr >> ADDR_WIDTH);
  assign unused_bits  = ^{bus_data_in[0:2], bus_data_in[4], bus_data_in[6:13]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rmw_d   = rmw_q;
    nxm_d   = 1'b0;
    mem_we  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_addr_cycle_in && !bus_io_cycle_in && (req_rd || req_wr)) begin
          if (out_of_range) begin
            nxm_d = 1'b1;
          end else begin
            addr_d = req_addr[ADDR_WIDTH-1:0];
            rmw_d  = req_rd & req_wr;
            cnt_d  = '0;
            if (req_rd) state_d = (RD_LAT == 1) ? StRdData : StRdWait;
            else        state_d = StWrWait;
          end
        end
      end
      StRdWait: begin
        if (cnt_q == RdLast) state_d = StRdData;
        else                 cnt_d   = cnt_q + 16'd1;
      end
      StRdData: begin
        // RMW keeps the claimed address for the write half
        if (rmw_q) begin
          state_d = StWrWait;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StWrWait: begin
        if (bus_data_cycle_in) begin
          mem_we  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == WrLast) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rmw_q   <= 1'b0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rmw_q   <= rmw_d;
      nxm_q   <= nxm_d;
    end
  end

  // Single port: in IDLE the incoming address is presented so RD_LAT=1 still works.
  assign mem_addr = (state_q == StIdle) ? req_addr[ADDR_WIDTH-1:0] : addr_q;

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= bus_data_in;
    rdata_q <= mem[mem_addr];
  end

  assign bus_data_cycle_out = (state_q == StRdData);
  assign bus_mem_busy_out   = (state_q != StIdle);
  assign bus_data_out       = (state_q == StRdData) ? rdata_q : '0;
  assign mem_nxm            = nxm_q;
  assign mem_wr_abort       = abort & ~rst;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: write/read, RMW, NXM, write timeout,
// ignored strobes and reset mid-reference.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_cyc, data_cyc, io_cyc;
  logic [0:35] din;
  logic        dco, busy, nxm, abort;
  logic [0:35] dout;

  int checks   = 0;
  int failures = 0;

  localparam logic [35:0] RD  = 36'h1_0000_0000;  // bit 3 in [0:35] numbering
  localparam logic [35:0] WR  = 36'h0_4000_0000;  // bit 5
  localparam logic [35:0] D1  = 36'o123456701234;

  mem_bus_responder #(.ADDR_WIDTH(14), .RD_LAT(2), .WR_TIMEOUT(15)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus_addr_cycle_in  (addr_cyc),
    .bus_data_cycle_in  (data_cyc),
    .bus_io_cycle_in    (io_cyc),
    .bus_data_in        (din),
    .bus_data_cycle_out (dco),
    .bus_mem_busy_out   (busy),
    .bus_data_out       (dout),
    .mem_nxm            (nxm),
    .mem_wr_abort       (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, drive idle inputs.
  task automatic next();
    @(posedge clk);
    #1;
    addr_cyc = 1'b0;
    data_cyc = 1'b0;
    io_cyc   = 1'b0;
    rst      = 1'b0;
    din      = '0;
  endtask

  task automatic settle();
    #2;
  endtask

  // Write with the data cycle two clocks after the address cycle.
  task automatic do_write(input logic [35:0] a, input logic [35:0] d);
    next(); addr_cyc = 1'b1; din = WR | a; settle();
    chk("wr_busy_c0", 36'(busy), 36'd0);
    next(); settle();
    chk("wr_busy_c1", 36'(busy), 36'd1);
    next(); data_cyc = 1'b1; din = d; settle();
    chk("wr_busy_c2", 36'(busy), 36'd1);
    next(); settle();
    chk("wr_busy_c3", 36'(busy), 36'd0);
  endtask

  task automatic do_read(input logic [35:0] a, input logic [35:0] exp);
    next(); addr_cyc = 1'b1; din = RD | a; settle();
    chk("rd_dco_c0", 36'(dco), 36'd0);
    next(); settle();
    chk("rd_dco_c1", 36'(dco), 36'd0);
    chk("rd_busy_c1", 36'(busy), 36'd1);
    next(); settle();
    chk("rd_dco_c2", 36'(dco), 36'd1);
    chk("rd_data_c2", dout, exp);
    next(); settle();
    chk("rd_dco_c3", 36'(dco), 36'd0);
    chk("rd_dout_c3", dout, 36'd0);
    chk("rd_busy_c3", 36'(busy), 36'd0);
  endtask

  initial begin
    rst = 1'b1; addr_cyc = 1'b0; data_cyc = 1'b0; io_cyc = 1'b0; din = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; settle();
    chk("rst_busy", 36'(busy), 36'd0);
    chk("rst_dco", 36'(dco), 36'd0);
    chk("rst_dout", dout, 36'd0);
    chk("rst_nxm", 36'(nxm), 36'd0);
    chk("rst_abort", 36'(abort), 36'd0);

    // Write then read
    do_write(36'o100, D1);
    do_read(36'o100, D1);

    // Read-modify-write on 0o200
    do_write(36'o200, 36'o7);
    next(); addr_cyc = 1'b1; din = RD | WR | 36'o200; settle();
    next(); settle();
    chk("rmw_busy_c1", 36'(busy), 36'd1);
    next(); settle();
    chk("rmw_dco_c2", 36'(dco), 36'd1);
    chk("rmw_data_c2", dout, 36'o7);
    next(); settle();
    chk("rmw_busy_c3", 36'(busy), 36'd1);
    chk("rmw_dco_c3", 36'(dco), 36'd0);
    next(); data_cyc = 1'b1; din = 36'o10; settle();
    chk("rmw_busy_c4", 36'(busy), 36'd1);
    next(); settle();
    chk("rmw_busy_c5", 36'(busy), 36'd0);
    do_read(36'o200, 36'o10);

    // NXM at 2**14
    next(); addr_cyc = 1'b1; din = RD | 36'd16384; settle();
    next(); settle();
    chk("nxm_pulse", 36'(nxm), 36'd1);
    chk("nxm_busy", 36'(busy), 36'd0);
    chk("nxm_dco", 36'(dco), 36'd0);
    chk("nxm_dout", dout, 36'd0);
    next(); settle();
    chk("nxm_pulse_end", 36'(nxm), 36'd0);
    chk("nxm_dco_c2", 36'(dco), 36'd0);

    // Write timeout on 0o300
    do_write(36'o300, 36'o555);
    next(); addr_cyc = 1'b1; din = WR | 36'o300; settle();
    begin
      int early = 0;
      for (int i = 1; i <= 14; i++) begin
        next(); settle();
        if (abort !== 1'b0 || busy !== 1'b1) early++;
      end
      chk("to_early", 36'(early), 36'd0);
    end
    next(); settle();
    chk("to_abort_c15", 36'(abort), 36'd1);
    chk("to_busy_c15", 36'(busy), 36'd1);
    next(); settle();
    chk("to_abort_c16", 36'(abort), 36'd0);
    chk("to_busy_c16", 36'(busy), 36'd0);
    do_read(36'o300, 36'o555);

    // IO cycle and stray data cycle
    next(); addr_cyc = 1'b1; io_cyc = 1'b1; din = RD | 36'o100; settle();
    next(); settle();
    chk("io_busy", 36'(busy), 36'd0);
    next(); settle();
    chk("io_dco", 36'(dco), 36'd0);
    next(); data_cyc = 1'b1; din = 36'o777; settle();
    chk("stray_busy", 36'(busy), 36'd0);
    do_read(36'o100, D1);

    // Reset during RD_WAIT
    next(); addr_cyc = 1'b1; din = RD | 36'o100; settle();
    next(); rst = 1'b1; settle();
    next(); settle();
    chk("rstmid_busy", 36'(busy), 36'd0);
    chk("rstmid_dco", 36'(dco), 36'd0);
    next(); settle();
    chk("rstmid_dco_c3", 36'(dco), 36'd0);
    do_read(36'o100, D1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
